// File: rtl/exec_ctl_pkg.sv
// ---------------------------------------------------------------------------
// exec_ctl_pkg
// Shared definitions for the execution-control block: the mode encoding
// seen on the board display and the widths of the debounce and step
// counters.
// ---------------------------------------------------------------------------
package exec_ctl_pkg;

    localparam int DBNC_W     = 20;
    localparam int STEP_CNT_W = 32;

    // 2'b11 is never entered; the FSM treats it as HALT.
    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_RUN  = 2'b10
    } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw, bouncy push-button: 2-flop synchronizer, stability
// counter, and a one-cycle press pulse on each accepted 0->1 transition.
// Releases are accepted silently.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-low reset
//   i_btn    raw button level (asynchronous, active-high)
//   o_press  registered one-cycle press pulse
// ---------------------------------------------------------------------------
module btn_debounce
    import exec_ctl_pkg::*;
#(
    parameter logic [DBNC_W-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    logic [1:0]        sync_q;
    logic [DBNC_W-1:0] cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;

    // The counter runs only while the synchronized level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DBNC_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/clk_en_ctl.sv
// ---------------------------------------------------------------------------
// clk_en_ctl
// Drives the single-cycle datapath clock enable from two board buttons and
// a halt request: HALT holds the core, STEP gives one enable per step
// press, RUN gives one enable every RUN_DIV cycles.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-low reset
//   i_btn_step    raw step button
//   i_btn_mode    raw mode button (HALT -> STEP -> RUN -> HALT)
//   i_halt_req    single-cycle stop request from the control decoder
//   o_clk_enable  registered datapath enable
//   o_mode        current mode (also the FSM state for observation)
//   o_step_count  number of cycles with o_clk_enable high
// ---------------------------------------------------------------------------
module clk_en_ctl
    import exec_ctl_pkg::*;
#(
    parameter logic [DBNC_W-1:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [7:0]        RUN_DIV         = 8'd4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_btn_step,
    input  logic                  i_btn_mode,
    input  logic                  i_halt_req,
    output logic                  o_clk_enable,
    output logic [1:0]            o_mode,
    output logic [STEP_CNT_W-1:0] o_step_count
);

    logic step_press;
    logic mode_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_step (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_step),
        .o_press (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_mode (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_mode),
        .o_press (mode_press)
    );

    mode_e           mode_q;
    logic [7:0]      presc_q;
    logic            en_q;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

    // Mode FSM with registered enable. The prescaler defaults to 0 every
    // cycle outside RUN, so each entry into RUN starts a fresh period.
    // A halt request overrides everything, including an enable the
    // prescaler would have produced in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mode_q  <= MODE_HALT;
            presc_q <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q    <= 1'b0;
            presc_q <= '0;
            if (i_halt_req) begin
                mode_q <= MODE_HALT;
            end else begin
                case (mode_q)
                    MODE_HALT: begin
                        if (mode_press) mode_q <= MODE_STEP;
                    end
                    MODE_STEP: begin
                        // A step press arriving with a mode press is dropped.
                        if (mode_press)      mode_q <= MODE_RUN;
                        else if (step_press) en_q   <= 1'b1;
                    end
                    MODE_RUN: begin
                        if (mode_press) mode_q <= MODE_HALT;
                        if (presc_q == RUN_DIV - 8'd1) en_q    <= 1'b1;
                        else                           presc_q <= presc_q + 8'd1;
                    end
                    default: mode_q <= MODE_HALT;
                endcase
            end
        end
    end

    always_comb begin
        step_cnt_d = step_cnt_q + STEP_CNT_W'(en_q);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) step_cnt_q <= '0;
        else        step_cnt_q <= step_cnt_d;
    end

    assign o_clk_enable = en_q;
    assign o_mode       = mode_q;
    assign o_step_count = step_cnt_q;

endmodule

// File: tb/tb_clk_en_ctl.sv
module tb_clk_en_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_step;
  logic        btn_mode;
  logic        halt;
  logic        en;
  logic [1:0]  mode;
  logic [31:0] cnt;

  clk_en_ctl #(.DEBOUNCE_CYCLES(20'd4), .RUN_DIV(8'd3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_btn_step   (btn_step),
    .i_btn_mode   (btn_mode),
    .i_halt_req   (halt),
    .o_clk_enable (en),
    .o_mode       (mode),
    .o_step_count (cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  // Each expected enable pulse pushes the count value the DUT must show
  // during that pulse; the monitor pops on every observed pulse.
  logic [31:0] exp_q[$];
  logic [31:0] model_cnt;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (rst === 1'b1 && en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("en_unexpected", 32'(en), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("en_count", cnt, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mode_press(input logic [1:0] from_m, input logic [1:0] to_m);
    btn_mode = 1'b1;
    repeat (7) @(negedge clk);
    check_val("mode_before", 32'(mode), 32'(from_m));
    @(negedge clk);
    check_val("mode_after", 32'(mode), 32'(to_m));
  endtask

  task automatic release_mode();
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic step_press(input int hold);
    exp_q.push_back(model_cnt);
    model_cnt++;
    btn_step = 1'b1;
    repeat (8) @(negedge clk);
    check_val("step_en", 32'(en), 32'd1);
    @(negedge clk);
    check_val("step_width", 32'(en), 32'd0);
    repeat (hold - 9) @(negedge clk);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] cnt0;
  logic        exp_en;

  initial begin
    rst = 1'b0; btn_step = 1'b0; btn_mode = 1'b0; halt = 1'b0;
    model_cnt = '0;
    repeat (3) @(negedge clk);
    check_val("rst_en", 32'(en), 32'd0);
    check_val("rst_mode", 32'(mode), 32'd0);
    check_val("rst_cnt", cnt, 32'd0);
    rst = 1'b1;

    // Bounce rejection: 2 high / 2 low never reaches the 4-sample window.
    for (int i = 0; i < 20; i++) begin
      btn_mode = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check_val("bounce_mode", 32'(mode), 32'd0);
    check_val("bounce_en", 32'(en), 32'd0);
    check_val("bounce_cnt", cnt, 32'd0);

    // Clean press: STEP appears exactly 8 cycles after the rise.
    mode_press(2'b00, 2'b01);
    release_mode();

    // STEP: three presses, the last held 100 cycles.
    step_press(10);
    step_press(10);
    step_press(100);
    check_val("step_cnt3", cnt, 32'd3);
    check_val("step_sb_empty", 32'(exp_q.size()), 32'd0);

    // RUN: entry observed at loop index 0; enables at 3,6,..,30.
    mode_press(2'b01, 2'b10);
    cnt0 = cnt;
    for (int i = 1; i <= 40; i++) begin
      exp_en = (i % 3 == 0) && (i <= 30);
      if (exp_en) begin
        exp_q.push_back(model_cnt);
        model_cnt++;
      end
      @(negedge clk);
      check_val("run_en", 32'(en), 32'(exp_en));
      if (i == 2)  btn_mode = 1'b0;
      if (i == 25) btn_mode = 1'b1;       // press pulse lands in cycle 32
      if (i == 31) check_val("run_cnt10", cnt, cnt0 + 32'd10);
      if (i == 32) halt = 1'b1;           // prescaler is at 2 in this cycle
      if (i == 33) begin
        halt = 1'b0;
        check_val("halt_mode", 32'(mode), 32'd0);
        check_val("halt_cnt", cnt, cnt0 + 32'd10);
      end
      if (i == 35) btn_mode = 1'b0;
      if (i > 33) check_val("halt_hold", 32'(mode), 32'd0);
    end
    repeat (10) @(negedge clk);

    // STEP with halt, mode press and step press all in one cycle.
    mode_press(2'b00, 2'b01);
    release_mode();
    btn_mode = 1'b1;
    btn_step = 1'b1;
    repeat (7) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_val("coinc_mode", 32'(mode), 32'd0);
    check_val("coinc_en", 32'(en), 32'd0);
    repeat (3) @(negedge clk);
    check_val("coinc_en_late", 32'(en), 32'd0);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    repeat (10) @(negedge clk);

    // Counter wrap.
    mode_press(2'b00, 2'b01);
    release_mode();
    force dut.step_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.step_cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    step_press(10);
    check_val("wrap_cnt", cnt, 32'd0);

    // Asynchronous reset in RUN, applied while the enable is high.
    mode_press(2'b01, 2'b10);
    for (int i = 1; i <= 6; i++) begin
      exp_en = (i % 3 == 0);
      if (exp_en) begin
        exp_q.push_back(model_cnt);
        model_cnt++;
      end
      @(negedge clk);
      check_val("run2_en", 32'(en), 32'(exp_en));
      if (i == 2) btn_mode = 1'b0;
    end
    #1;
    rst = 1'b0;
    #1;
    check_val("arst_en", 32'(en), 32'd0);
    check_val("arst_mode", 32'(mode), 32'd0);
    check_val("arst_cnt", cnt, 32'd0);
    model_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_mode", 32'(mode), 32'd0);
    check_val("post_rst_en", 32'(en), 32'd0);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_en_ctl.md
# clk_en_ctl

Execution-control block that drives the single-cycle datapath's clock-enable input from two board push-buttons and a halt request, so the core can be held, single-stepped or free-run from the board. It sits directly upstream of the datapath:

- `o_clk_enable` connects to the datapath clock enable.
- `i_halt_req` comes from the control decoder, e.g. on ebreak/ecall.
- `o_step_count` is exposed for the board display.

## Interface
- DEBOUNCE_CYCLES, default 20'd500000: consecutive stable synchronized samples required before a button level is accepted; legal range 1..2^20-1.
- RUN_DIV, default 8'd4: in RUN, `o_clk_enable` pulses once every RUN_DIV cycles; legal range 1..255; RUN_DIV=1 gives continuous enable.
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  reset, asynchronous, active-low.
- i_btn_step  input  1  raw step button, asynchronous, active-high, bouncy.
- i_btn_mode  input  1  raw mode button, asynchronous, active-high, bouncy.
- i_halt_req  input  1  synchronous single-cycle request to stop execution.
- o_clk_enable  output  1  registered datapath enable.
- o_mode  output  2  current mode: 2'b00 HALT, 2'b01 STEP, 2'b10 RUN.
- o_step_count  output  32  number of cycles in which `o_clk_enable` was high.

## Operation
**Reset values.** While `i_rst` is low:
- `o_clk_enable` = 0, `o_mode` = HALT, `o_step_count` = 0.
- Prescaler = 0; debounced levels = 0; synchronizers = 0.

**Button conditioning** (identical for each button):
- 2-flop synchronizer.
- Debouncer: a counter increments while the synchronized level differs from the accepted level and clears to 0 whenever they match.
- When the counter reaches DEBOUNCE_CYCLES, the accepted level takes the synchronized level and the counter clears.
- Press pulse: one cycle high on a 0->1 transition of the accepted level. Releases produce nothing.

**Mode FSM** (states HALT, STEP, RUN; encoding 2'b11 is unreachable and recovers to HALT):
- Mode press: HALT->STEP->RUN->HALT.
- `i_halt_req` high: next state is HALT from any state.
- `i_halt_req` beats a simultaneous mode press.

**Enable generation:**
- **HALT:** enable 0; step presses ignored.
- **STEP:** each step press produces exactly one enable cycle. A step press coinciding with a mode press or halt request is dropped.
- **RUN:**
  - The prescaler counts 0..RUN_DIV-1 and wraps.
  - Enable is high when the prescaler = RUN_DIV-1.
  - The prescaler clears to 0 on every entry to RUN.
  - Step presses are ignored.
  - In the cycle `i_halt_req` is sampled, the pending enable is suppressed.
- **Step counter:** `o_step_count` increments by 1 on every cycle `o_clk_enable` is high and wraps 32'hFFFF_FFFF -> 0. It is never cleared except by reset.

## Timing
- Raw button rise, held stable, to press pulse: 2 synchronizer + DEBOUNCE_CYCLES + 1 cycles.
- Press pulse to `o_mode` change: 1 cycle (registered).
- Step press pulse to `o_clk_enable` high: 1 cycle; enable stays high for exactly 1 cycle.
- RUN entry to first enable: RUN_DIV cycles after `o_mode` becomes RUN. After that, enable has period RUN_DIV with duty 1 cycle.
- `i_halt_req` at cycle n:
  - `o_mode` = HALT at n+1.
  - `o_clk_enable` is 0 at n+1 and thereafter, even if the prescaler would have fired.
- `o_step_count` updates the cycle after the enable-high cycle.
- Reset assertion mid-operation: all outputs go to reset values immediately (asynchronously). Deassertion is synchronized externally; the block needs no extra handling.

## Structure
- Shared package `exec_ctl_pkg`:
  - mode encodings MODE_HALT, MODE_STEP, MODE_RUN;
  - width constants DBNC_W = 20 and STEP_CNT_W = 32.
- Sub-module `btn_debounce`: synchronizer + debouncer + press-pulse edge detect, parameterized by DEBOUNCE_CYCLES. Instantiated twice, once per button.
- The top level holds the mode FSM, prescaler, enable register and step counter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=3, 1 cycle = 1 clock.
- **Reset and bounce rejection.** Hold `i_rst` low, then release. Bounce `i_btn_mode` 1/0 every 2 cycles for 20 cycles.
  - Expected: `o_mode` stays 2'b00, enable 0, count 0.
- **Clean mode press.** Apply one clean mode press (high 10 cycles).
  - Expected: `o_mode` = 2'b01 exactly 2+4+1+1 = 8 cycles after the rise.
- **STEP mode.** In STEP, apply three clean step presses.
  - Expected: exactly three single-cycle enable pulses; `o_step_count` = 3; holding the button high for 100 cycles yields no extra pulse.
- **RUN mode.** Enter RUN and run 30 cycles.
  - Expected: enable high on cycles 3, 6, …, 30 after entry; count increases by 10.
- **Halt priority.** In RUN, pulse `i_halt_req` in the same cycle the prescaler is at 2, and simultaneously with a mode press pulse.
  - Expected: enable stays 0; `o_mode` = 2'b00 the next cycle; count unchanged.
- **Wrap and async reset.** Force `o_step_count` to 32'hFFFF_FFFF, then issue a step.
  - Expected: count = 0.
  - Then drop `i_rst` mid-RUN between clock edges: all outputs return to reset values before the next edge.
